// File: rtl/ex_mem_skid_reg.sv
// EX/MEM elastic pipeline register: valid/ready handshake with a one-entry skid
// buffer so ready_o toward EX is a pure register output, plus flush and a stall counter.
module ex_mem_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [DATA_W-1:0]  ALUResult_i,
  input  logic [DATA_W-1:0]  RS2data_i,
  input  logic [RADDR_W-1:0] RDaddr_i,
  input  logic               RegWrite_i,
  input  logic               MemtoReg_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DATA_W-1:0]  ALUResult_o,
  output logic [DATA_W-1:0]  RS2data_o,
  output logic [RADDR_W-1:0] RDaddr_o,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high
  // on that side; push (EX side) and pop (MEM side) are evaluated on the same edge.

  typedef struct packed {
    logic [DATA_W-1:0]  alu;
    logic [DATA_W-1:0]  rs2;
    logic [RADDR_W-1:0] rd;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
  } beat_t;

  // Bit 0 = main entry valid, bit 1 = skid entry valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t           state_q;
  beat_t            main_q;
  beat_t            skid_q;
  beat_t            in_beat;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             push;
  logic             pop;

  assign in_beat = {ALUResult_i, RS2data_i, RDaddr_i,
                    RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};

  assign ready_o = ~state_q[1];
  assign valid_o = state_q[0];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_o && !ready_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (flush_i) begin
        // Contents are dropped but payload bits keep their last value.
        state_q <= ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              main_q  <= in_beat;
              state_q <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_q <= in_beat;
            end else if (push) begin
              skid_q  <= in_beat;
              state_q <= ST_FULL;
            end else if (pop) begin
              state_q <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (pop) begin
              main_q  <= skid_q;
              state_q <= ST_ONE;
            end
          end
          default: state_q <= ST_EMPTY;
        endcase
      end
    end
  end

  assign ALUResult_o = main_q.alu;
  assign RS2data_o   = main_q.rs2;
  assign RDaddr_o    = main_q.rd;
  assign RegWrite_o  = main_q.reg_write  & valid_o;
  assign MemtoReg_o  = main_q.mem_to_reg & valid_o;
  assign MemRead_o   = main_q.mem_read   & valid_o;
  assign MemWrite_o  = main_q.mem_write  & valid_o;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: pushes expected beats into a queue on accept,
// a negedge monitor pops and compares each beat MEM consumes.
module tb_ex_mem_skid_reg;
  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;
  localparam int BEAT_W  = 2*DATA_W + RADDR_W + 4;

  logic               clk = 1'b0;
  logic               rst_i, flush_i, valid_i, ready_o, valid_o, ready_i;
  logic [DATA_W-1:0]  alu_i, rs2_i, alu_o, rs2_o;
  logic [RADDR_W-1:0] rd_i, rd_o;
  logic               rw_i, m2r_i, mr_i, mw_i, rw_o, m2r_o, mr_o, mw_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  logic [BEAT_W-1:0]  exp_q[$];
  int                 total = 0;
  int                 bad   = 0;

  ex_mem_skid_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .ALUResult_i(alu_i), .RS2data_i(rs2_i), .RDaddr_i(rd_i),
    .RegWrite_i(rw_i), .MemtoReg_i(m2r_i), .MemRead_i(mr_i), .MemWrite_i(mw_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .ALUResult_o(alu_o), .RS2data_o(rs2_o), .RDaddr_o(rd_o),
    .RegWrite_o(rw_o), .MemtoReg_o(m2r_o), .MemRead_o(mr_o), .MemWrite_o(mw_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and expectation recorder, sampled mid-cycle where all signals are stable.
  always @(negedge clk) begin
    if (!rst_i) begin
      exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", {79'd0, valid_o}, 80'd0);
        end else begin
          check("pop_beat", {11'd0, alu_o, rs2_o, rd_o, rw_o, m2r_o, mr_o, mw_o},
                {11'd0, exp_q.pop_front()});
        end
      end
      if (flush_i) begin
        exp_q.delete();
      end else if (valid_i && ready_o) begin
        exp_q.push_back({alu_i, rs2_i, rd_i, rw_i, m2r_i, mr_i, mw_i});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] s,
                      input logic [RADDR_W-1:0] r, input logic [3:0] ctl);
    valid_i = 1'b1;
    alu_i = a;
    rs2_i = s;
    rd_i  = r;
    {rw_i, m2r_i, mr_i, mw_i} = ctl;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    step(2);
    rst_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    beat(32'hDEADBEEF, 32'h1, 5'd7, 4'b1111);

    // Reset with a valid beat on the input.
    step(2);
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_ready_o", ready_o, 1'b1);
    check("rst_payload", {alu_o, rs2_o, rd_o}, '0);
    check("rst_ctrl", {rw_o, m2r_o, mr_o, mw_o}, 4'b0000);
    check("rst_stall", stall_cnt_o, 4'd0);

    // First beat after reset release appears one cycle later.
    rst_i = 1'b1; ready_i = 1'b0;
    step();
    check("lat_valid_o", valid_o, 1'b1);
    check("lat_alu", alu_o, 32'hDEADBEEF);
    idle(); ready_i = 1'b1;
    step();

    // Streaming with ready_i=1.
    for (int i = 5; i <= 7; i++) begin
      beat(i, 32'h0, 5'd1, 4'b1000);
      step();
      check("stream_alu", alu_o, i);
      check("stream_ready", ready_o, 1'b1);
    end
    idle();
    step(2);
    check("stream_valid_drained", valid_o, 1'b0);
    check("stream_stall", stall_cnt_o, 4'd0);

    // Backpressure: two beats fill main and skid.
    ready_i = 1'b0;
    beat(32'h10, 32'h0, 5'd3, 4'b1000);
    step();
    beat(32'h20, 32'h0, 5'd4, 4'b1000);
    step();
    idle();
    check("full_ready", ready_o, 1'b0);
    step(3);
    check("full_hold", {alu_o, rd_o, rw_o}, {32'h10, 5'd3, 1'b1});
    check("full_stall4", stall_cnt_o, 4'd4);
    ready_i = 1'b1;
    step();
    check("after_popA_ready", ready_o, 1'b1);
    check("after_popA_alu", alu_o, 32'h20);
    step();
    check("after_popB_valid", valid_o, 1'b0);
    check("after_popB_rw", rw_o, 1'b0);
    check("after_popB_stall", stall_cnt_o, 4'd4);

    // Flush while FULL with an incoming beat.
    ready_i = 1'b0;
    beat(32'h30, 32'h0, 5'd5, 4'b1001);
    step();
    beat(32'h31, 32'h0, 5'd6, 4'b1001);
    step();
    beat(32'h99, 32'h0, 5'd9, 4'b1001);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; idle();
    check("flush_full_valid", valid_o, 1'b0);
    check("flush_full_ctrl", {rw_o, mw_o}, 2'b00);
    check("flush_full_ready", ready_o, 1'b1);

    // Flush in ONE state while an accepted-looking beat is offered.
    beat(32'h50, 32'h0, 5'd2, 4'b1000);
    step();
    beat(32'h51, 32'h0, 5'd2, 4'b1000);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; idle();
    check("flush_one_valid", valid_o, 1'b0);
    step();
    check("flush_one_dropped", valid_o, 1'b0);
    ready_i = 1'b1;
    step();

    // Store passthrough.
    ready_i = 1'b0;
    beat(32'h40, 32'hCAFEF00D, 5'd0, 4'b0001);
    step();
    idle();
    check("store_payload", {alu_o, rs2_o, mw_o}, {32'h40, 32'hCAFEF00D, 1'b1});
    ready_i = 1'b1;
    step();
    check("store_mw_gated", mw_o, 1'b0);
    check("store_rs2_hold", rs2_o, 32'hCAFEF00D);

    // Stall counter saturation.
    do_reset();
    check("sat_rst_stall", stall_cnt_o, 4'd0);
    ready_i = 1'b0;
    beat(32'h77, 32'h0, 5'd8, 4'b0100);
    step();
    idle();
    step(20);
    check("sat_15", stall_cnt_o, 4'd15);
    step(2);
    check("sat_hold", stall_cnt_o, 4'd15);
    do_reset();
    check("sat_cleared", stall_cnt_o, 4'd0);
    check("sat_rst_valid", valid_o, 1'b0);

    // Everything accepted and not flushed must have been consumed.
    ready_i = 1'b1;
    step(2);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Elastic EX/MEM pipeline register directly downstream of the execute-stage ALU.
- Captures the ALU result, store data, destination register and MEM/WB control bits, and presents them to the MEM stage.
- Uses a valid/ready handshake backed by a one-entry skid buffer, so the ready path toward EX is fully registered.
- Adds a synchronous flush and a saturating stall-cycle counter for hazard and performance debug.

Parameters:
DATA_W, 32, width of ALU result and store data
RADDR_W, 5, width of destination register index
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset; synchronous, active-low
flush_i  input  1  kill all held entries and the incoming beat
valid_i  input  1  EX presents a valid instruction
ready_o  output  1  register can accept a beat this cycle
ALUResult_i  input  DATA_W  ALU data_o
RS2data_i  input  DATA_W  store data for sw
RDaddr_i  input  RADDR_W  destination register
RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  input  1 each  control bits
valid_o  output  1  MEM-side entry valid
ready_i  input  1  MEM stage accepts the entry this cycle
ALUResult_o, RS2data_o  output  DATA_W  oldest entry payload
RDaddr_o  output  RADDR_W  oldest entry destination
RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  output  1 each  control bits, gated by valid_o
stall_cnt_o  output  CNT_W  cycles with valid_o=1 and ready_i=0, saturating

Behaviour:
- Push = valid_i & ready_o. Pop = valid_o & ready_i. Both are evaluated on the same edge.
- Storage:
  - main entry drives the outputs.
  - skid entry holds the overflow beat.
  - Order is strict FIFO; main is always the oldest entry.
- ready_o = ~skid_valid. This is a registered state bit with no combinational path from ready_i.
- States and transitions:
  - EMPTY (main=0, skid=0):
    - push -> ONE.
    - Latency: a beat accepted in cycle N appears on the outputs in cycle N+1.
  - ONE (main=1, skid=0):
    - push & pop -> ONE; main loads the new beat.
    - push only -> FULL; the new beat goes to skid.
    - pop only -> EMPTY.
    - neither -> hold.
  - FULL (main=1, skid=1):
    - ready_o=0, so no push is possible.
    - pop -> ONE; skid moves to main and ready_o=1 in the next cycle.
    - no pop -> hold all payload bits stable.
- Output gating:
  - RegWrite_o, MemtoReg_o, MemRead_o and MemWrite_o are forced to 0 when valid_o=0.
  - ALUResult_o, RS2data_o and RDaddr_o hold their last value when invalid; only the control bits are gated.
- Payload is stored bit-exact; no arithmetic. Signedness is irrelevant.
- flush_i=1 (synchronous):
  - Next state is EMPTY, ready_o=1 and the incoming beat is discarded.
  - flush overrides push and pop in the same cycle.
  - A pop presented in the flush cycle still counts as consumed by MEM; the register only drops its contents.
- stall_cnt_o:
  - Increments when valid_o & ~ready_i.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush_i; cleared only by reset.
- Reset (rst_i=0 at a rising edge):
  - valid_o=0, ready_o=1, all payload outputs and control outputs =0, stall_cnt_o=0, state EMPTY.
  - Reset overrides flush, push and pop, including mid-FULL.
- Payload changes on the outputs only on a pop, or on a push into EMPTY.

Test Plan:
- Reset with valid_i=1, ALUResult_i=32'hDEADBEEF -> valid_o=0, ready_o=1, all outputs 0, stall_cnt_o=0. The first beat after rst_i=1 appears one cycle later.
- Streaming with ready_i=1: push add results 5, 6, 7 in consecutive cycles -> outputs 5, 6, 7 on cycles N+1..N+3; ready_o stays 1; stall_cnt_o=0.
- Backpressure: push A=0x10 (RegWrite=1, RDaddr=3) then B=0x20 with ready_i=0 -> FULL, ready_o=0. Hold ready_i=0 four cycles -> A held stable and stall_cnt_o=4. Raise ready_i -> A then B popped in order, ready_o=1 the cycle after A pops.
- Flush while FULL with valid_i=1 -> next cycle valid_o=0, RegWrite_o/MemWrite_o=0, ready_o=1; the incoming beat is never output.
- Store passthrough: MemWrite_i=1, RS2data_i=32'hCAFEF00D, ALUResult_i=0x40 -> same values on the outputs. After the pop with no new push, MemWrite_o=0.
- Saturation with CNT_W=4: hold valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o=15 and stays 15. Reset -> 0.
